// File: rtl/rr_mux_arb_pkg.sv
// Shared types and the round-robin scan helper for rr_mux_arb_4.
// Provides N_REQ, req_id_t, pick_t, slot_state_t and rr_next().
package rr_mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_id_t;

    typedef struct packed {
        logic    found;
        req_id_t id;
    } pick_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Scan ptr+1, ptr+2, ptr+3, ptr (mod 4); first valid one wins.
    function automatic pick_t rr_next(
        input req_id_t          ptr,
        input logic [N_REQ-1:0] valid
    );
        pick_t   r;
        req_id_t idx;
        r = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr + req_id_t'(k);
            if (!r.found && valid[idx]) begin
                r.found = 1'b1;
                r.id    = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: priority pointer + valids -> grant.
// Ports: ptr, valid[3:0] in; grant[3:0] (one-hot or zero), win_id, found out.
module rr_pick_4
    import rr_mux_arb_pkg::*;
(
    input  req_id_t          ptr,
    input  logic [N_REQ-1:0] valid,
    output logic [N_REQ-1:0] grant,
    output req_id_t          win_id,
    output logic             found
);

    pick_t pick;

    always_comb begin
        pick   = rr_next(ptr, valid);
        found  = pick.found;
        win_id = pick.id;
        grant  = '0;
        if (pick.found) begin
            grant[pick.id] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_arb_4.sv
// Round-robin arbiter feeding a 4:1 select into a one-entry output slot.
// Ports: clk, rst_n, req_valid/req_data/req_ready (x4), out_valid/out_data/
// out_id/out_ready; grant_cnt and CNT_W exist only with RR_MUX_ARB_STATS_EN.
module rr_mux_arb_4
    import rr_mux_arb_pkg::*;
#(
    parameter int W = 4
`ifdef RR_MUX_ARB_STATS_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [1:0]         out_id,
    input  logic               out_ready
`ifdef RR_MUX_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

    slot_state_t      state;
    slot_state_t      state_nxt;
    req_id_t          ptr;
    req_id_t          win_id;
    logic             found;
    logic [N_REQ-1:0] grant;
    logic             slot_free;
    logic             load;
    logic [W-1:0]     sel_data;

    rr_pick_4 u_pick (
        .ptr    (ptr),
        .valid  (req_valid),
        .grant  (grant),
        .win_id (win_id),
        .found  (found)
    );

    assign out_valid = (state == FULL);
    assign slot_free = !out_valid || out_ready;
    assign req_ready = slot_free ? grant : '0;
    assign load      = slot_free && found;

    always_comb begin
        sel_data = '0;
        unique case (win_id)
            2'd0: sel_data = req_data[0*W +: W];
            2'd1: sel_data = req_data[1*W +: W];
            2'd2: sel_data = req_data[2*W +: W];
            2'd3: sel_data = req_data[3*W +: W];
        endcase
    end

    // Slot stays FULL when drained and refilled on the same edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (found) state_nxt = FULL;
            FULL:  if (out_ready && !found) state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= 2'd3;
            out_data <= '0;
            out_id   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_data <= sel_data;
                out_id   <= win_id;
                ptr      <= win_id;
            end
        end
    end

`ifdef RR_MUX_ARB_STATS_EN
    logic [N_REQ-1:0] fire;
    logic [CNT_W-1:0] cnt_q [N_REQ];

    assign fire = req_ready & req_valid;

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        // Saturating: holds at all-ones instead of wrapping.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[g] <= '0;
            end else if (fire[g] && (cnt_q[g] != '1)) begin
                cnt_q[g] <= cnt_q[g] + 1'b1;
            end
        end
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_rr_mux_arb_4.sv
// Randomized self-checking bench for rr_mux_arb_4 with a behavioural model.
// Covers reset, rotation, single requester, backpressure, async reset, stats.
module tb_rr_mux_arb_4;

`ifdef RR_MUX_ARB_STATS_EN
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
`else
    localparam int CMAX = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
`ifdef RR_MUX_ARB_STATS_EN
    logic [4*CW-1:0] grant_cnt;
`endif

    int checks = 0;
    int failures = 0;

    bit         m_valid;
    logic [3:0] m_data;
    logic [1:0] m_id;
    int         m_ptr;
    int         m_cnt [4];

    always #5 clk = ~clk;

`ifdef RR_MUX_ARB_STATS_EN
    rr_mux_arb_4 #(.W(4), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .grant_cnt (grant_cnt)
    );
`else
    rr_mux_arb_4 #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );
`endif

    function automatic int winner(int ptr, logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        bit free;
        int w;
        free = !m_valid || out_ready;
        w = winner(m_ptr, req_valid);
        if (free && w >= 0) return 4'(1 << w);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data = 4'h0;
        m_id = 2'd0;
        m_ptr = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic tick();
        bit free;
        int w;
        free = !m_valid || out_ready;
        w = winner(m_ptr, req_valid);
        @(posedge clk);
        if (free) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data = req_data[w*4 +: 4];
                m_id = 2'(w);
                m_ptr = w;
                if (m_cnt[w] < CMAX) m_cnt[w]++;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req_valid = 4'b0;
        req_data = 16'h0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_outs got v=%b d=%h id=%0d exp v=0 d=0 id=0",
                     out_valid, out_data, out_id);
        end
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL idle_ready got=%b exp=0000", req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_data !== 4'h0 || out_id !== 2'd0) begin
                failures++;
                $display("FAIL idle_outs got v=%b d=%h id=%0d exp v=0 d=0 id=0",
                         out_valid, out_data, out_id);
            end
        end
    endtask

    task automatic test_round_robin();
        int         exp_ids [5];
        logic [3:0] exp_d [5];
        exp_ids = '{0, 1, 2, 3, 0};
        exp_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        req_valid = 4'b1111;
        req_data = 16'hDCBA;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #2;
            checks++;
            if (req_ready !== exp_ready() || !$onehot(req_ready)) begin
                failures++;
                $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'(exp_ids[c]) || out_data !== exp_d[c]) begin
                failures++;
                $display("FAIL rr_out c=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                         c, out_valid, out_id, out_data, exp_ids[c], exp_d[c]);
            end
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_data = {4'h3, 4'h5, 4'h9, 4'h1};
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++;
            if (req_ready !== 4'b0100) begin
                failures++;
                $display("FAIL single_ready c=%0d got=%b exp=0100", c, req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 4'h5) begin
                failures++;
                $display("FAIL single_out c=%0d got v=%b id=%0d d=%h exp v=1 id=2 d=5",
                         c, out_valid, out_id, out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1111;
        req_data = 16'hDCBA;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_ready c=%0d got=%b exp=0000", c, req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 4'h5) begin
                failures++;
                $display("FAIL bp_hold c=%0d got v=%b id=%0d d=%h exp v=1 id=2 d=5",
                         c, out_valid, out_id, out_data);
            end
        end
        out_ready = 1'b1;
        #2;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=1000", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 4'hD) begin
            failures++;
            $display("FAIL bp_release_out got v=%b id=%0d d=%h exp v=1 id=3 d=d",
                     out_valid, out_id, out_data);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_id !== 2'd0 || out_data !== 4'h0) begin
            failures++;
            $display("FAIL async_reset got v=%b id=%0d d=%h exp v=0 id=0 d=0",
                     out_valid, out_id, out_data);
        end
        req_valid = 4'b0000;
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        req_valid = 4'b1111;
        req_data = 16'hDCBA;
        out_ready = 1'b1;
        #2;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL post_reset_ready got=%b exp=0001", req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 4'hA) begin
            failures++;
            $display("FAIL post_reset_out got v=%b id=%0d d=%h exp v=1 id=0 d=a",
                     out_valid, out_id, out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            req_data = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            checks++;
            if (req_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_id !== m_id || out_data !== m_data) begin
                failures++;
                $display("FAIL rand_out c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                         c, out_valid, out_id, out_data, m_valid, m_id, m_data);
            end
`ifdef RR_MUX_ARB_STATS_EN
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_cnt[i*CW +: CW] !== CW'(m_cnt[i])) begin
                    failures++;
                    $display("FAIL rand_cnt%0d got=%0d exp=%0d",
                             i, grant_cnt[i*CW +: CW], m_cnt[i]);
                end
            end
`endif
        end
    endtask

`ifdef RR_MUX_ARB_STATS_EN
    task automatic test_stats();
        logic [4*CW-1:0] exp_cnt;
        exp_cnt = {2'd0, 2'd0, 2'd3, 2'd0};
        req_valid = 4'b0000;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        tick();
        req_valid = 4'b0010;
        req_data = 16'h0070;
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (grant_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL stats_sat got=%h exp=%h", grant_cnt, exp_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_async_reset();
        test_random();
`ifdef RR_MUX_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
